// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU sequencer.
// Contents: opcode values, ALU op codes, the sequencer state type and the
// decoded-instruction flag bundle that passes from cpu_decode to cpu_ctrl.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_WID = 4;

  localparam logic [3:0] OPC_NOP  = 4'b0000;
  localparam logic [3:0] OPC_LDI  = 4'b0001;
  localparam logic [3:0] OPC_LD   = 4'b0010;
  localparam logic [3:0] OPC_ST   = 4'b0011;
  localparam logic [3:0] OPC_JMP  = 4'b0100;
  localparam logic [3:0] OPC_JS   = 4'b0101;
  localparam logic [3:0] OPC_RSV  = 4'b0110;
  localparam logic [3:0] OPC_HALT = 4'b0111;

  // ALU op codes (opc[2:0] of a 1xxx instruction)
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef struct packed {
    logic is_mem;   // needs a data memory access (LD, ST, ALU)
    logic is_st;
    logic is_alu;
    logic is_jmp;
    logic is_js;
    logic is_ldi;
    logic is_halt;
  } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder for cpu_ctrl.
// Ports:
//   opc_i  in  4      instruction opcode
//   dec_o  out dec_t  decoded flags {is_mem,is_st,is_alu,is_jmp,is_js,is_ldi,is_halt}
module cpu_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opc_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    if (opc_i[3]) begin
      dec_o.is_alu = 1'b1;
      dec_o.is_mem = 1'b1;
    end else begin
      unique case (opc_i)
        OPC_LDI:  dec_o.is_ldi  = 1'b1;
        OPC_LD:   dec_o.is_mem  = 1'b1;
        OPC_ST: begin
          dec_o.is_mem = 1'b1;
          dec_o.is_st  = 1'b1;
        end
        OPC_JMP:  dec_o.is_jmp  = 1'b1;
        OPC_JS:   dec_o.is_js   = 1'b1;
        OPC_HALT: dec_o.is_halt = 1'b1;
        default:  ;  // NOP and reserved: no flags
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
// Drives cpu_alu (op/a/b/si) and writes its result back into ACC and S.
// Ports:
//   clk, rst                          clock, async active-high reset
//   imem_req/addr/rdata/ack           instruction fetch handshake
//   dmem_req/we/addr/wdata/rdata/ack  data memory handshake
//   alu_op/si/a/b, alu_r/so           ALU operands out, result in
//   acc, halted                       accumulator, halt indication
//   retire_cnt                        instruction retire counter, present only
//                                     when CPU_CTRL_RETIRE_CNT_EN is defined
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned       REG_WID = 10,
  parameter int unsigned       PC_WID  = 8,
  parameter logic [PC_WID-1:0] RST_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [PC_WID-1:0]          imem_addr,
  input  logic [OPC_WID+REG_WID-1:0] imem_rdata,
  input  logic                       imem_ack,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [REG_WID-1:0]         dmem_addr,
  output logic [REG_WID-1:0]         dmem_wdata,
  input  logic [REG_WID-1:0]         dmem_rdata,
  input  logic                       dmem_ack,
  output logic [2:0]                 alu_op,
  output logic                       alu_si,
  output logic [REG_WID-1:0]         alu_a,
  output logic [REG_WID-1:0]         alu_b,
  input  logic [REG_WID-1:0]         alu_r,
  input  logic                       alu_so,
  output logic [REG_WID-1:0]         acc,
  output logic                       halted
`ifdef CPU_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]                retire_cnt
`endif
);

  state_t                       state_q;
  logic [PC_WID-1:0]            pc_q;
  logic [OPC_WID+REG_WID-1:0]   ir_q;
  logic [REG_WID-1:0]           acc_q;
  logic                         s_q;
  logic [REG_WID-1:0]           opnd_q;
  logic                         imem_req_q;
  logic                         dmem_req_q;
  logic                         dmem_we_q;
  logic                         halted_q;

  logic [OPC_WID-1:0]           opc;
  logic [REG_WID-1:0]           fld;
  dec_t                         dec;

  assign opc = ir_q[OPC_WID+REG_WID-1:REG_WID];
  assign fld = ir_q[REG_WID-1:0];

  cpu_decode u_decode (
    .opc_i (opc),
    .dec_o (dec)
  );

  // imem_req is registered, so the first FETCH after reset spends one cycle
  // raising it; an ack is only taken while the request is actually up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RST_PC;
      ir_q       <= '0;
      acc_q      <= '0;
      s_q        <= 1'b0;
      opnd_q     <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (imem_ack) begin
            imem_req_q <= 1'b0;
            ir_q       <= imem_rdata;
            pc_q       <= pc_q + 1'b1;
            state_q    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec.is_halt) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (dec.is_mem) begin
            state_q    <= ST_MEM;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= dec.is_st;
          end else begin
            if (dec.is_ldi) acc_q <= fld;
            if (dec.is_jmp || (dec.is_js && s_q)) pc_q <= fld[PC_WID-1:0];
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (dec.is_alu) begin
              opnd_q  <= dmem_rdata;
              state_q <= ST_EXEC;
            end else begin
              if (!dec.is_st) acc_q <= dmem_rdata;
              state_q    <= ST_FETCH;
              imem_req_q <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          acc_q      <= alu_r;
          s_q        <= alu_so;
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
        end
        ST_HALT: ;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic        retire;
  logic [15:0] retire_cnt_q;
  logic [15:0] retire_cnt_d;

  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_DECODE: retire = !dec.is_mem;
      ST_MEM:    retire = dmem_ack && !dec.is_alu;
      ST_EXEC:   retire = 1'b1;
      default:   retire = 1'b0;
    endcase
    retire_cnt_d = retire ? retire_cnt_q + 16'd1 : retire_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt_q <= '0;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = fld;
  assign dmem_wdata = acc_q;
  assign alu_op     = opc[2:0];
  assign alu_si     = s_q;
  assign alu_a      = acc_q;
  assign alu_b      = opnd_q;
  assign acc        = acc_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [13:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic [9:0]  dmem_addr;
  logic [9:0]  dmem_wdata;
  logic [9:0]  dmem_rdata;
  logic        dmem_ack;
  logic [2:0]  alu_op;
  logic        alu_si;
  logic [9:0]  alu_a;
  logic [9:0]  alu_b;
  logic [9:0]  alu_r;
  logic        alu_so;
  logic [9:0]  acc;
  logic        halted;
`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  cpu_ctrl #(.REG_WID(10), .PC_WID(8), .RST_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .alu_op     (alu_op),
    .alu_si     (alu_si),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_r      (alu_r),
    .alu_so     (alu_so),
    .acc        (acc),
    .halted     (halted)
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory responders: ack once the request has waited *_wait cycles.
  logic [13:0] imem [0:255];
  logic [9:0]  dmem [0:1023];
  int unsigned imem_wait = 0;
  int unsigned dmem_wait = 0;
  int unsigned icnt = 0;
  int unsigned dcnt = 0;

  assign imem_ack   = imem_req && (icnt >= imem_wait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
  end

  // Reference ALU
  always_comb begin
    alu_r  = alu_a;
    alu_so = 1'b0;
    case (alu_op)
      3'b000: alu_r = alu_a & alu_b;
      3'b001: alu_r = alu_a | alu_b;
      3'b100: {alu_so, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b101: begin alu_r = alu_a - alu_b; alu_so = (alu_a < alu_b); end
      3'b110: alu_r = alu_a ^ alu_b;
      3'b111: alu_r = ~alu_a;
      default: begin alu_r = alu_a; alu_so = 1'b0; end
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [13:0] ins(input logic [3:0] o, input logic [9:0] f);
    return {o, f};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = ins(4'b0111, 10'h000);
    for (int i = 0; i < 1024; i++) dmem[i] = 10'h000;
    imem_wait = 0;
    dmem_wait = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_fetch(input logic [7:0] a, input string nm);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (imem_req && imem_addr == a) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL %s: no fetch at 0x%02h seen, last addr 0x%02h", nm, a, imem_addr);
    else n_pass++;
  endtask

  task automatic wait_halt(input string nm);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (halted) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL %s: halted never rose, got %0b want 1", nm, halted);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_mem();
    imem[0] = ins(4'b0001, 10'h005);
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({imem_req, dmem_req, dmem_we, halted} !== 4'b0000) $display("FAIL reset_req: got %b want 0000", {imem_req, dmem_req, dmem_we, halted});
    else n_pass++;
    n_checks++;
    if ({acc, alu_si, imem_addr, alu_b} !== 29'd0) $display("FAIL reset_regs: acc=%h s=%b pc=%h opnd=%h want 0", acc, alu_si, imem_addr, alu_b);
    else n_pass++;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    n_checks++;
    if (retire_cnt !== 16'd0) $display("FAIL reset_retire: got %0d want 0", retire_cnt);
    else n_pass++;
`endif
    rst = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL first_fetch: req=%b addr=%h want 1/00", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_ldi_halt();
    clear_mem();
    imem[0] = ins(4'b0001, 10'h005);
    imem[1] = ins(4'b0111, 10'h000);
    do_reset();
    tick();               // req raised, acked this cycle
    tick();               // DECODE
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 8'h01 || acc !== 10'h000) $display("FAIL ldi_decode: req=%b pc=%h acc=%h want 0/01/000", imem_req, imem_addr, acc);
    else n_pass++;
    tick();
    n_checks++;
    if (acc !== 10'h005 || alu_si !== 1'b0 || imem_req !== 1'b1) $display("FAIL ldi_done: acc=%h s=%b req=%b want 005/0/1", acc, alu_si, imem_req);
    else n_pass++;
    wait_halt("halt_rise");
    begin
      int reqs = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (imem_req || !halted) reqs++; end
      n_checks++;
      if (reqs != 0) $display("FAIL halt_quiet: %0d bad cycles want 0", reqs);
      else n_pass++;
    end
    n_checks++;
    if (imem_addr !== 8'h02) $display("FAIL halt_pc: got %h want 02", imem_addr);
    else n_pass++;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    n_checks++;
    if (retire_cnt !== 16'd2) $display("FAIL retire_ldi_halt: got %0d want 2", retire_cnt);
    else n_pass++;
`endif
    do_reset();
    n_checks++;
    if (halted !== 1'b0 || imem_addr !== 8'h00) $display("FAIL halt_reset: halted=%b pc=%h want 0/00", halted, imem_addr);
    else n_pass++;
  endtask

  task automatic test_alu_add();
    int n = 0;
    clear_mem();
    imem[0] = ins(4'b0001, 10'h005);
    imem[1] = ins(4'b1100, 10'h003);
    dmem[3] = 10'h007;
    dmem_wait = 2;
    do_reset();
    wait_fetch(8'h01, "add_fetch");
    for (int i = 0; i < 10 && !dmem_req; i++) tick();
    for (int i = 0; i < 20 && dmem_req; i++) begin
      if (dmem_we !== 1'b0 || dmem_addr !== 10'h003) n = n + 100;
      n++;
      tick();
    end
    n_checks++;
    if (n != 3) $display("FAIL add_req_len: got %0d want 3", n);
    else n_pass++;
    n_checks++;
    if (acc !== 10'h005 || alu_b !== 10'h007 || alu_op !== 3'b100) $display("FAIL add_exec: acc=%h b=%h op=%b want 005/007/100", acc, alu_b, alu_op);
    else n_pass++;
    tick();
    n_checks++;
    if (acc !== 10'h00C || alu_si !== 1'b0) $display("FAIL add_result: acc=%h s=%b want 00c/0", acc, alu_si);
    else n_pass++;
  endtask

  task automatic test_sub_js();
    clear_mem();
    imem[0]     = ins(4'b0001, 10'h003);
    imem[1]     = ins(4'b1101, 10'h004);
    imem[2]     = ins(4'b0101, 10'h020);
    imem[8'h20] = ins(4'b1010, 10'h000);  // pass-through clears S
    imem[8'h21] = ins(4'b0101, 10'h050);
    imem[8'h22] = ins(4'b0111, 10'h000);
    dmem[4] = 10'h005;
    do_reset();
    wait_fetch(8'h02, "sub_to_js");
    n_checks++;
    if (acc !== 10'h3FE || alu_si !== 1'b1) $display("FAIL sub_result: acc=%h s=%b want 3fe/1", acc, alu_si);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h20) $display("FAIL js_taken: req=%b pc=%h want 1/20", imem_req, imem_addr);
    else n_pass++;
    wait_halt("js_halt");
    n_checks++;
    if (imem_addr !== 8'h23 || acc !== 10'h3FE || alu_si !== 1'b0) $display("FAIL js_not_taken: pc=%h acc=%h s=%b want 23/3fe/0", imem_addr, acc, alu_si);
    else n_pass++;
  endtask

  task automatic test_store();
    int n = 0;
    int bad = 0;
    clear_mem();
    imem[0] = ins(4'b0001, 10'h155);
    imem[1] = ins(4'b0011, 10'h02A);
    dmem_wait = 3;
    do_reset();
    for (int i = 0; i < 20 && !dmem_req; i++) tick();
    for (int i = 0; i < 20 && dmem_req; i++) begin
      if (dmem_we !== 1'b1 || dmem_addr !== 10'h02A || dmem_wdata !== 10'h155) bad++;
      n++;
      tick();
    end
    n_checks++;
    if (n != 4 || bad != 0) $display("FAIL st_handshake: cycles=%0d bad=%0d want 4/0", n, bad);
    else n_pass++;
    n_checks++;
    if (dmem_we !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h02) $display("FAIL st_done: we=%b req=%b pc=%h want 0/1/02", dmem_we, imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_ld_nop();
    clear_mem();
    imem[0] = ins(4'b0010, 10'h010);
    imem[1] = ins(4'b0000, 10'h3FF);
    imem[2] = ins(4'b0110, 10'h001);
    dmem[10'h010] = 10'h2AB;
    dmem_wait = 1;
    do_reset();
    wait_halt("ld_halt");
    n_checks++;
    if (acc !== 10'h2AB || imem_addr !== 8'h04) $display("FAIL ld_nop: acc=%h pc=%h want 2ab/04", acc, imem_addr);
    else n_pass++;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    n_checks++;
    if (retire_cnt !== 16'd4) $display("FAIL retire_ld: got %0d want 4", retire_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    imem[0]     = ins(4'b0100, 10'h0FF);
    imem[8'hFF] = ins(4'b0000, 10'h000);
    do_reset();
    wait_fetch(8'hFF, "jmp_ff");
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 8'h00) $display("FAIL pc_wrap: req=%b pc=%h want 0/00", imem_req, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL wrap_refetch: req=%b pc=%h want 1/00", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mem();
    clear_mem();
    imem[0] = ins(4'b0001, 10'h099);
    imem[1] = ins(4'b0010, 10'h010);
    dmem_wait = 100;
    do_reset();
    for (int i = 0; i < 20 && !dmem_req; i++) tick();
    repeat (2) tick();
    n_checks++;
    if (dmem_req !== 1'b1 || acc !== 10'h099) $display("FAIL mem_wait: req=%b acc=%h want 1/099", dmem_req, acc);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0) $display("FAIL rst_drop: dreq=%b ireq=%b want 0/0", dmem_req, imem_req);
    else n_pass++;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || acc !== 10'h000 || halted !== 1'b0) $display("FAIL rst_recover: req=%b pc=%h acc=%h halted=%b want 1/00/000/0", imem_req, imem_addr, acc, halted);
    else n_pass++;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    n_checks++;
    if (retire_cnt !== 16'd0) $display("FAIL rst_retire: got %0d want 0", retire_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_ldi_halt();
    test_alu_add();
    test_sub_js();
    test_store();
    test_ld_nop();
    test_pc_wrap();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
